sysid_ext_slave: RTL
====================

SYSID_EXT_SLAVE -- requirements
Module: sysid_ext_slave

Interface
REQ-001 Parameter SYSTEM_ID, default 32'h0000_0000, value returned by the ID register.
REQ-002 Parameter TIMESTAMP, default 32'h0000_0000, build time in seconds, returned by the TIMESTAMP register.
REQ-003 Parameter TICK_DIV, default 50, clock cycles per uptime tick; legal range 1..65535.
REQ-004 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-005 clock  input  1  sole clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 address  input  3  Avalon-MM word address.
REQ-008 read  input  1  read request, one-cycle strobe per transfer.
REQ-009 write  input  1  write request, one-cycle strobe per transfer.
REQ-010 writedata  input  32  write data.
REQ-011 byteenable  input  4  byte lanes for writes; bit n covers writedata[8n+7:8n].
REQ-012 readdata  output  32  registered read data.
REQ-013 readdatavalid  output  1  high for exactly one cycle when readdata is valid.

Function
REQ-014 The register map SHALL be: 0 ID (RO), 1 TIMESTAMP (RO), 2 UPTIME_LO (RO), 3 UPTIME_HI (RO), 4 SCRATCH (RW), 5 CTRL (RW), 6 TICK_DIV (RO, zero-extended), 7 reserved (reads 0).
REQ-015 The block SHALL never stall; reads have fixed latency 1: a read accepted at edge N drives readdata and readdatavalid=1 after edge N+1's setup, i.e. valid in cycle N+1.
REQ-016 readdatavalid SHALL be 0 in every cycle not following an accepted read; readdata holds its last value when readdatavalid=0.
REQ-017 When read and write are both high in one cycle, the read SHALL be serviced and the write discarded.
REQ-018 The prescaler SHALL count 0..TICK_DIV-1 and wrap to 0; each wrap increments a 64-bit uptime counter by 1, while CTRL.EN=1.
REQ-019 When CTRL.EN=0 the prescaler and uptime counter SHALL hold.
REQ-020 The uptime counter SHALL wrap from 2^64-1 to 0 without flag.
REQ-021 A read of UPTIME_LO SHALL return counter bits [31:0] and, in the same edge, copy bits [63:32] into a shadow register; UPTIME_HI SHALL return the shadow, never the live value.
REQ-022 If a tick carries into bit 32 on the same edge that UPTIME_LO is read, the returned LO and shadow SHALL both be the pre-increment value.
REQ-023 SCRATCH writes SHALL update only byte lanes with byteenable set.
REQ-024 CTRL bit0 EN is RW; bit1 CLR is write-1 action reading 0; bits 31:2 read 0 and ignore writes.
REQ-025 Writing CLR=1 SHALL zero the prescaler, uptime counter and shadow on that edge, overriding any tick that edge; EN takes the written bit0 value on the same edge.
REQ-026 CTRL writes SHALL take effect only if byteenable[0]=1.
REQ-027 Writes to RO or reserved addresses SHALL be ignored with no side effect.
REQ-028 Reads SHALL have no side effect other than REQ-021.

Reset
REQ-029 While reset is high at an edge: readdata=0, readdatavalid=0, SCRATCH=0, CTRL.EN=1, prescaler=0, uptime=0, shadow=0.
REQ-030 A read accepted on the edge where reset is high SHALL be dropped (no readdatavalid afterwards).
REQ-031 The first tick after reset release SHALL occur TICK_DIV cycles after the first non-reset edge.

Verification
REQ-032 SYSTEM_ID=32'h5521_7AFD, read addr 0 -> next cycle readdata=32'h5521_7AFD, readdatavalid=1 for one cycle only.
REQ-033 TICK_DIV=4, release reset, wait 40 cycles, read addr 2 -> readdata=10; read addr 3 -> 0.
REQ-034 Force uptime to 64'h0000_0001_FFFF_FFFF via CLR-free preload/backdoor, read addr 2 on carry edge -> LO=32'hFFFF_FFFF, then addr 3 -> 1.
REQ-035 Write SCRATCH 32'hA5A5_A5A5 be=4'hF, then 32'h1234_5678 be=4'b0101 -> read returns 32'hA534_A578.
REQ-036 Write CTRL=0, wait 20 cycles, uptime unchanged; write CTRL=3 -> uptime reads 0, counting resumes.
REQ-037 Assert read and write to addr 4 together -> SCRATCH unchanged, readdatavalid=1 with old value; assert reset mid-count -> all values per REQ-029 next cycle.

Source files
------------

// File: rtl/sysid_ext_slave.sv
// rtl/sysid_ext_slave.sv - system ID / build timestamp / uptime register slave
//
// Purpose:
//   Avalon-MM style register slave exposing a fixed system ID, a build
//   timestamp, a free-running 64-bit uptime counter (advanced once every
//   TICK_DIV clocks while enabled), a scratch register and a small control
//   register. Reads are answered with a fixed latency of one cycle and the
//   slave never stalls.
//
// Ports:
//   clock          sole clock, rising edge
//   reset          synchronous active-high reset
//   address[2:0]   word address
//   read           read strobe, one cycle per transfer
//   write          write strobe, one cycle per transfer
//   writedata[31:0] write data
//   byteenable[3:0] write byte lanes, bit n covers writedata[8n+7:8n]
//   readdata[31:0] registered read data, holds when readdatavalid is low
//   readdatavalid  one-cycle pulse in the cycle after an accepted read
//
// Register map:
//   0 ID         RO  SYSTEM_ID
//   1 TIMESTAMP  RO  TIMESTAMP
//   2 UPTIME_LO  RO  uptime[31:0]; latches uptime[63:32] into the shadow
//   3 UPTIME_HI  RO  shadow of uptime[63:32] taken at the last LO read
//   4 SCRATCH    RW  byte-lane writable
//   5 CTRL       RW  bit0 EN, bit1 CLR (write-1 action, reads 0)
//   6 TICK_DIV   RO  TICK_DIV zero-extended
//   7 reserved       reads 0

module sysid_ext_slave #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
  parameter int unsigned TICK_DIV  = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd3;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd4;
  localparam logic [2:0] ADDR_CTRL      = 3'd5;
  localparam logic [2:0] ADDR_TICK_DIV  = 3'd6;

  // Prescaler terminal count; TICK_DIV is limited to 1..65535 so 16 bits suffice.
  localparam logic [15:0] PRESC_MAX  = 16'(TICK_DIV - 1);
  localparam logic [31:0] TICK_DIV_W = 32'(TICK_DIV);

  logic [15:0] presc_q,    presc_d;
  logic [63:0] uptime_q,   uptime_d;
  logic [31:0] shadow_q,   shadow_d;
  logic [31:0] scratch_q,  scratch_d;
  logic        en_q,       en_d;
  logic [31:0] readdata_q, readdata_d;
  logic        rvalid_q,   rvalid_d;

  logic        wr_acc;
  logic        ctrl_wr;
  logic        clr;
  logic        tick;

  always_comb begin
    // A simultaneous read wins; the write in that cycle is dropped entirely.
    wr_acc  = write & ~read;
    ctrl_wr = wr_acc && (address == ADDR_CTRL) && byteenable[0];
    clr     = ctrl_wr && writedata[1];
    tick    = en_q && (presc_q == PRESC_MAX);

    presc_d    = presc_q;
    uptime_d   = uptime_q;
    shadow_d   = shadow_q;
    scratch_d  = scratch_q;
    en_d       = en_q;
    readdata_d = readdata_q;
    rvalid_d   = read;

    // Prescaler and uptime. CLR overrides any tick landing on the same edge.
    if (clr) begin
      presc_d  = 16'h0000;
      uptime_d = 64'h0;
    end else if (en_q) begin
      if (tick) begin
        presc_d  = 16'h0000;
        uptime_d = uptime_q + 64'd1;
      end else begin
        presc_d  = presc_q + 16'd1;
      end
    end

    if (ctrl_wr) begin
      en_d = writedata[0];
    end

    // Shadow capture uses the pre-increment counter so LO and HI stay coherent
    // even when a tick carries into bit 32 on the read edge. A CLR write can
    // never coincide with a read, so the two branches are exclusive.
    if (clr) begin
      shadow_d = 32'h0;
    end else if (read && (address == ADDR_UPTIME_LO)) begin
      shadow_d = uptime_q[63:32];
    end

    if (wr_acc && (address == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch_d[8*i +: 8] = writedata[8*i +: 8];
        end
      end
    end

    if (read) begin
      case (address)
        ADDR_ID:        readdata_d = SYSTEM_ID;
        ADDR_TIMESTAMP: readdata_d = TIMESTAMP;
        ADDR_UPTIME_LO: readdata_d = uptime_q[31:0];
        ADDR_UPTIME_HI: readdata_d = shadow_q;
        ADDR_SCRATCH:   readdata_d = scratch_q;
        ADDR_CTRL:      readdata_d = {31'h0, en_q};
        ADDR_TICK_DIV:  readdata_d = TICK_DIV_W;
        default:        readdata_d = 32'h0;
      endcase
    end
  end

  // Reset also drops any read presented on a reset edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q    <= 16'h0000;
      uptime_q   <= 64'h0;
      shadow_q   <= 32'h0;
      scratch_q  <= 32'h0;
      en_q       <= 1'b1;
      readdata_q <= 32'h0;
      rvalid_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      uptime_q   <= uptime_d;
      shadow_q   <= shadow_d;
      scratch_q  <= scratch_d;
      en_q       <= en_d;
      readdata_q <= readdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rvalid_q;

endmodule
